// File: rtl/serv_arb_pkg.sv
// serv_arb_pkg
// Shared definitions for the SERV instruction/data bus arbiter:
//   - 2-bit state encoding (IDLE, GNT_I, GNT_D, TURN) and the enum built on it
//   - the constant byte-enable value driven for instruction fetches
package serv_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GNT_I = ST_GNT_I,
        GNT_D = ST_GNT_D,
        TURN  = ST_TURN
    } arb_state_t;

    // Instruction fetches always read a full word.
    localparam logic [3:0] IBUS_SEL = 4'hF;

endpackage

// File: rtl/serv_arb_wdog.sv
// serv_arb_wdog
// Stall watchdog for the bus arbiter. Counts granted cycles that pass
// without a slave acknowledge and flags expiry once the count is all-ones.
// Only instantiated when SERV_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   clear    restart the count (asserted on the grant edge)
//   active   a transaction is currently granted
//   ack      slave acknowledge for the current transaction
//   expired  count reached all-ones while granted
module serv_arb_wdog #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    // The count parks at all-ones after expiry; the next grant clears it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (active && !ack && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = active && (count == '1);

endmodule

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter
// Shares one Wishbone-classic port between SERV's instruction and data buses.
// Fixed priority (dbus over ibus), grant held until the slave acks, registered
// shared-port outputs, and one forced idle (TURN) cycle after every completion.
// Optional feature macro: SERV_ARB_TIMEOUT_EN adds a stall watchdog that
// terminates a transaction after 2^TIMEOUT_W-1 unacknowledged granted cycles.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_ibus_adr/cyc, o_ibus_rdt/ack   instruction fetch requester
//   i_dbus_adr/dat/sel/we/cyc        data requester request fields
//   o_dbus_rdt/ack                   data requester response
//   o_wb_adr/dat/sel/we/cyc          shared slave port request (registered)
//   i_wb_rdt/ack                     shared slave port response
//   o_err                            one-cycle watchdog expiry pulse (0 when off)
module serv_bus_arbiter
    import serv_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [AW-1:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_err
);

    arb_state_t state;
    logic       granted;
    logic       ack_hit;
    logic       timeout;
    logic       done;

    assign granted = (state == GNT_I) || (state == GNT_D);

    // An ack arriving while reset is asserted belongs to a transaction that is
    // being abandoned, so it is not forwarded to the requester.
    assign ack_hit = granted && i_wb_ack && !i_rst;

`ifdef SERV_ARB_TIMEOUT_EN
    logic grant_now;
    logic expired;

    assign grant_now = (state == IDLE) && (i_dbus_cyc || i_ibus_cyc);

    serv_arb_wdog #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_wdog (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (grant_now),
        .active  (granted),
        .ack     (i_wb_ack),
        .expired (expired)
    );

    // A real ack on the expiry cycle wins and completes normally.
    assign timeout = expired && !i_wb_ack && !i_rst;
`else
    // Keeps the width parameter referenced when the watchdog is compiled out.
    logic [TIMEOUT_W-1:0] unused_stall_count;
    assign unused_stall_count = '0;
    assign timeout            = 1'b0;
`endif

    assign done = ack_hit || timeout;

    assign o_ibus_ack = (state == GNT_I) && done;
    assign o_dbus_ack = (state == GNT_D) && done;

    // Read data is a pass-through; a watchdog-terminated fetch returns zero.
    assign o_ibus_rdt = timeout ? 32'h0 : i_wb_rdt;
    assign o_dbus_rdt = timeout ? 32'h0 : i_wb_rdt;
    assign o_err      = timeout;

    // Arbitration FSM. The shared-port fields are captured on the grant edge
    // and held untouched until the transaction completes, so requester inputs
    // are ignored while granted. TURN absorbs a requester cyc that lingers one
    // cycle past its ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_dbus_cyc) begin
                        state    <= GNT_D;
                        o_wb_cyc <= 1'b1;
                        o_wb_adr <= i_dbus_adr;
                        o_wb_dat <= i_dbus_dat;
                        o_wb_sel <= i_dbus_sel;
                        o_wb_we  <= i_dbus_we;
                    end else if (i_ibus_cyc) begin
                        state    <= GNT_I;
                        o_wb_cyc <= 1'b1;
                        o_wb_adr <= i_ibus_adr;
                        o_wb_dat <= '0;
                        o_wb_sel <= IBUS_SEL;
                        o_wb_we  <= 1'b0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (done) begin
                        state    <= TURN;
                        o_wb_cyc <= 1'b0;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    o_wb_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule
